// File: rtl/vga_scanout_if.sv
// vga_scanout_if
//   Bundles the two sides of the scan-out engine: the pixel-read side toward
//   video memory (pxlAddr out, R/G/B back) and the video side toward the DAC
//   (colour, syncs, blank, pixel strobe, frame pulse).
//
//   master : the scan-out engine (drives pxlAddr and all video outputs,
//            samples R/G/B)
//   slave  : video memory / DAC side (drives R/G/B, observes everything else)
//
//   ADDR_W must match the ADDR_W of the vga_scanout instance it is bound to.
interface vga_scanout_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] pxlAddr;
    logic [7:0]        R;
    logic [7:0]        G;
    logic [7:0]        B;
    logic [7:0]        vgaR;
    logic [7:0]        vgaG;
    logic [7:0]        vgaB;
    logic              hsync;
    logic              vsync;
    logic              blank_n;
    logic              pxlStb;
    logic              frameStart;

    modport master (
        output pxlAddr,
        input  R, G, B,
        output vgaR, vgaG, vgaB,
        output hsync, vsync, blank_n,
        output pxlStb, frameStart
    );

    modport slave (
        input  pxlAddr,
        output R, G, B,
        input  vgaR, vgaG, vgaB,
        input  hsync, vsync, blank_n,
        input  pxlStb, frameStart
    );
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout
//   Read-side video timing engine. Generates 640x480@60 VGA timing from the
//   system clock, scans an IMG_W x IMG_H image placed at the top-left of the
//   active area, drives the pixel address to video memory and registers the
//   returned pixel onto the VGA outputs with syncs and blank aligned to it.
//
//   Parameters
//     CLK_DIV : system clocks per pixel (>= 2)
//     IMG_W   : image width in pixels  (<= 640)
//     IMG_H   : image height in lines  (<= 480)
//     ADDR_W  : pixel-address width, IMG_W*IMG_H <= 2**ADDR_W
//
//   Ports
//     clk    : system clock
//     reset  : asynchronous, active-high; clears all state
//     bus    : vga_scanout_if.master
//              pxlAddr          -> video memory read address
//              R/G/B            <- pixel data (must be valid CLK_DIV-1 clks
//                                  after pxlAddr changes)
//              vgaR/vgaG/vgaB   -> colour to DAC
//              hsync/vsync      -> active-low syncs
//              blank_n          -> high in the visible area
//              pxlStb           -> one-clk strobe per pixel period
//              frameStart       -> one-clk pulse when pixel (0,0) is issued
//
//   Pipeline
//     counters (h, v) --tick--> stage 1 (address + control)
//                     --tick--> stage 2 (colour + control on the pins)
module vga_scanout #(
    parameter int CLK_DIV = 2,
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int ADDR_W  = 18
) (
    input  logic          clk,
    input  logic          reset,
    vga_scanout_if.master bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_ACT_END  = 10'd640;
    localparam logic [9:0] H_SYNC_BEG = 10'd656;
    localparam logic [9:0] H_SYNC_END = 10'd751;
    localparam logic [9:0] H_LAST     = 10'd799;

    localparam logic [9:0] V_ACT_END  = 10'd480;
    localparam logic [9:0] V_SYNC_BEG = 10'd490;
    localparam logic [9:0] V_SYNC_END = 10'd491;
    localparam logic [9:0] V_LAST     = 10'd524;

    localparam logic [9:0]        IMG_W_C  = 10'(IMG_W);
    localparam logic [9:0]        IMG_H_C  = 10'(IMG_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    // ------------------------------------------------------------------
    // Timing state
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  divCnt;
    logic [9:0]        hCnt;
    logic [9:0]        vCnt;
    // Running v*IMG_W, so the address needs only an adder, not a multiplier.
    // It keeps counting past the image bottom; its value is ignored there.
    logic [ADDR_W-1:0] rowBase;

    logic              tick;
    logic              hWrap;
    logic              vWrap;
    logic [9:0]        hNext;
    logic [9:0]        vNext;
    logic [ADDR_W-1:0] rowBaseNext;

    // Decode of the current (h, v), registered into stage 1 on the tick
    logic              inImgNow;
    logic              actNow;
    logic              hsNow;
    logic              vsNow;
    logic [ADDR_W-1:0] addrNow;

    // Stage 1
    logic [ADDR_W-1:0] addrS1;
    logic              inImgS1;
    logic              actS1;
    logic              hsS1;
    logic              vsS1;

    // Stage 2
    logic [7:0]        pixIn  [3];
    logic [7:0]        pixOut [3];
    logic              blankS2;
    logic              hsyncS2;
    logic              vsyncS2;

    // Strobes
    logic              stbOut;
    logic              frameOut;

    // ------------------------------------------------------------------
    // Next-state and decode
    // ------------------------------------------------------------------
    always_comb begin
        tick        = (divCnt == DIV_LAST);
        hWrap       = (hCnt == H_LAST);
        vWrap       = (vCnt == V_LAST);

        hNext       = hWrap ? 10'd0 : hCnt + 10'd1;
        vNext       = vCnt;
        rowBaseNext = rowBase;
        if (hWrap) begin
            if (vWrap) begin
                vNext       = 10'd0;
                rowBaseNext = '0;
            end else begin
                vNext       = vCnt + 10'd1;
                rowBaseNext = rowBase + ROW_STEP;
            end
        end

        inImgNow = (hCnt < IMG_W_C) && (vCnt < IMG_H_C);
        addrNow  = inImgNow ? (rowBase + ADDR_W'(hCnt)) : '0;
        actNow   = (hCnt < H_ACT_END) && (vCnt < V_ACT_END);
        hsNow    = !((hCnt >= H_SYNC_BEG) && (hCnt <= H_SYNC_END));
        vsNow    = !((vCnt >= V_SYNC_BEG) && (vCnt <= V_SYNC_END));
    end

    // ------------------------------------------------------------------
    // Pixel divider and raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divCnt  <= '0;
            hCnt    <= 10'd0;
            vCnt    <= 10'd0;
            rowBase <= '0;
        end else begin
            divCnt <= tick ? '0 : divCnt + 1'b1;
            if (tick) begin
                hCnt    <= hNext;
                vCnt    <= vNext;
                rowBase <= rowBaseNext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Strobes: registered so that they coincide with the new pipeline
    // contents (the first one lands together with pixel (0,0) in stage 1).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stbOut   <= 1'b0;
            frameOut <= 1'b0;
        end else begin
            stbOut   <= tick;
            frameOut <= tick && (hCnt == 10'd0) && (vCnt == 10'd0);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: address and control for the current pixel.
    // Syncs idle high so stage 2 never sees a false sync pulse after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addrS1  <= '0;
            inImgS1 <= 1'b0;
            actS1   <= 1'b0;
            hsS1    <= 1'b1;
            vsS1    <= 1'b1;
        end else if (tick) begin
            addrS1  <= addrNow;
            inImgS1 <= inImgNow;
            actS1   <= actNow;
            hsS1    <= hsNow;
            vsS1    <= vsNow;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour from memory (black outside the image) and control
    // ------------------------------------------------------------------
    assign pixIn[0] = bus.R;
    assign pixIn[1] = bus.G;
    assign pixIn[2] = bus.B;

    for (genvar gi = 0; gi < 3; gi++) begin : gChan
        logic [7:0] chanQ;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                chanQ <= 8'd0;
            end else if (tick) begin
                chanQ <= inImgS1 ? pixIn[gi] : 8'd0;
            end
        end

        assign pixOut[gi] = chanQ;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blankS2 <= 1'b0;
            hsyncS2 <= 1'b1;
            vsyncS2 <= 1'b1;
        end else if (tick) begin
            blankS2 <= actS1;
            hsyncS2 <= hsS1;
            vsyncS2 <= vsS1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pxlAddr    = addrS1;
    assign bus.vgaR       = pixOut[0];
    assign bus.vgaG       = pixOut[1];
    assign bus.vgaB       = pixOut[2];
    assign bus.blank_n    = blankS2;
    assign bus.hsync      = hsyncS2;
    assign bus.vsync      = vsyncS2;
    assign bus.pxlStb     = stbOut;
    assign bus.frameStart = frameOut;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
//   Two instances: the default configuration (CLK_DIV=2, 256x256, 18-bit
//   address) and a small one (CLK_DIV=3, 20x4, 7-bit address) whose last
//   image pixel is reachable within a short run. Each has a mock video
//   memory with one clock of read latency. A reference model computes every
//   output from the pixel index (ticks since reset release) with plain
//   arithmetic; resets are inserted at random points mid-scan.
module tb_vga_scanout;

    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    vga_scanout_if #(.ADDR_W(18)) busA ();
    vga_scanout_if #(.ADDR_W(7))  busB ();

    vga_scanout #(.CLK_DIV(2), .IMG_W(256), .IMG_H(256), .ADDR_W(18)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busA.master)
    );

    vga_scanout #(.CLK_DIV(3), .IMG_W(20), .IMG_H(4), .ADDR_W(7)) dutS (
        .clk   (clk),
        .reset (reset),
        .bus   (busB.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Mock video memories, 1-clk read latency
    always @(posedge clk) begin
        busA.R <= busA.pxlAddr[7:0];
        busA.G <= busA.pxlAddr[15:8];
        busA.B <= 8'h5A;
        busB.R <= {1'b0, busB.pxlAddr};
        busB.G <= ~{1'b0, busB.pxlAddr};
        busB.B <= 8'hA5;
    end

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at t=%0t", name, actual, required, $time);
        end
    endtask

    // Reference model: outputs belonging to raster pixel number p
    function automatic void model(input longint p, input int inst,
                                  output logic [17:0] addr, output logic [23:0] rgb,
                                  output logic act, output logic hs, output logic vs);
        int h;
        int v;
        int imgW;
        int imgH;
        logic img;
        imgW = (inst == 0) ? 256 : 20;
        imgH = (inst == 0) ? 256 : 4;
        h    = int'(p % 800);
        v    = int'((p / 800) % 525);
        img  = (h < imgW) && (v < imgH);
        addr = img ? 18'(v * imgW + h) : 18'd0;
        if (!img)           rgb = 24'd0;
        else if (inst == 0) rgb = {addr[7:0], addr[15:8], 8'h5A};
        else                rgb = {1'b0, addr[6:0], ~{1'b0, addr[6:0]}, 8'hA5};
        act = (h < 640) && (v < 480);
        hs  = !(h >= 656 && h <= 751);
        vs  = !(v >= 490 && v <= 491);
    endfunction

    task automatic compareLoop(input int inst);
        longint e = 0;
        longint k;
        longint lineTick = -1;
        longint lastFall = -1;
        logic   prevHs = 1'b1;
        logic   stb;
        int     d;
        string  pfx;
        logic [17:0] aAddr, eAddr;
        logic [23:0] aRgb, eRgb;
        logic        aBl, aHs, aVs, aStb, aFs;
        logic        eAct, eHs, eVs, eStb, eFs;
        d   = (inst == 0) ? 2 : 3;
        pfx = (inst == 0) ? "A" : "S";
        forever begin
            @(posedge clk);
            if (reset) e = 0;
            else       e++;
            #1;
            if (inst == 0) begin
                aAddr = busA.pxlAddr;
                aRgb  = {busA.vgaR, busA.vgaG, busA.vgaB};
                aBl = busA.blank_n; aHs = busA.hsync; aVs = busA.vsync;
                aStb = busA.pxlStb; aFs = busA.frameStart;
            end else begin
                aAddr = 18'(busB.pxlAddr);
                aRgb  = {busB.vgaR, busB.vgaG, busB.vgaB};
                aBl = busB.blank_n; aHs = busB.hsync; aVs = busB.vsync;
                aStb = busB.pxlStb; aFs = busB.frameStart;
            end

            k    = e / d;
            stb  = (e != 0) && (e % d == 0);
            eStb = stb;
            eFs  = stb && ((k - 1) % 420000 == 0);
            eAddr = 18'd0;
            eRgb = 24'd0; eAct = 1'b0; eHs = 1'b1; eVs = 1'b1;
            if (k >= 1) model(k - 1, inst, eAddr, eRgb, eAct, eHs, eVs);
            if (k >= 2) model(k - 2, inst, eAddr, eRgb, eAct, eHs, eVs);
            // the stage-2 call overwrote eAddr; restore the stage-1 address
            if (k >= 1) begin
                logic [23:0] tRgb;
                logic tA, tH, tV;
                model(k - 1, inst, eAddr, tRgb, tA, tH, tV);
            end else begin
                eAddr = 18'd0;
            end
            if (k < 2) begin
                eRgb = 24'd0; eAct = 1'b0; eHs = 1'b1; eVs = 1'b1;
            end

            chk({pfx, ".pxlAddr"}, aAddr, eAddr);
            chk({pfx, ".video"}, {aRgb, aBl, aHs, aVs}, {eRgb, eAct, eHs, eVs});
            chk({pfx, ".strobes"}, {aStb, aFs}, {eStb, eFs});

            if (reset) begin
                lineTick = -1; lastFall = -1; prevHs = 1'b1;
            end else begin
                if (e == 1) chk({pfx, ".noStbFirstEdge"}, aStb, 1'b0);
                if (e == d) chk({pfx, ".firstStbFrame"}, {aStb, aFs}, 2'b11);
                if (stb && inst == 0) begin
                    if (k - 1 == 1601) chk("A.addr(1,2)", aAddr, 18'd513);
                    if (k - 2 == 1601) chk("A.rgb(1,2)", aRgb, 24'h01025A);
                    if (k - 1 == 255)  chk("A.addr(255,0)", aAddr, 18'd255);
                    if (k - 1 == 256)  chk("A.addr(256,0)", aAddr, 18'd0);
                    if (k - 1 == 8300) chk("A.addr(300,10)", aAddr, 18'd0);
                    if (k - 2 == 8300) chk("A.border(300,10)", {aRgb, aBl}, {24'd0, 1'b1});
                    if (k - 2 == 8700) chk("A.blank(700,10)", {aRgb, aBl}, 25'd0);
                    if ((k - 1) % 800 == 0) lineTick = k;
                    if (prevHs && !aHs) begin
                        if (lastFall >= 0) chk("A.hsPeriod", 64'(k - lastFall), 64'd800);
                        if (lineTick >= 0) chk("A.hsFallOffset", 64'(k - lineTick), 64'd657);
                        lastFall = k;
                    end
                    if (!prevHs && aHs && lastFall >= 0) chk("A.hsLow", 64'(k - lastFall), 64'd96);
                    prevHs = aHs;
                end
                if (stb && inst == 1) begin
                    if (k - 1 == 3 * 800 + 19) chk("S.lastAddr", aAddr, 18'd79);
                    if (k - 1 == 3 * 800 + 20) chk("S.pastWidth", aAddr, 18'd0);
                    if (k - 1 == 4 * 800)      chk("S.pastHeight", aAddr, 18'd0);
                end
            end
        end
    endtask

    initial compareLoop(0);
    initial compareLoop(1);

    task automatic checkResetNow();
        chk("A.resetImmediate",
            {busA.pxlAddr, busA.vgaR, busA.vgaG, busA.vgaB, busA.blank_n,
             busA.hsync, busA.vsync, busA.pxlStb, busA.frameStart},
            {18'd0, 24'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        chk("S.resetImmediate",
            {busB.pxlAddr, busB.vgaR, busB.vgaG, busB.vgaB, busB.blank_n,
             busB.hsync, busB.vsync, busB.pxlStb, busB.frameStart},
            {7'd0, 24'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (18000) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #($urandom_range(1, 3));
            reset = 1'b1;
            #1;
            checkResetNow();
            repeat ($urandom_range(1, 5)) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            repeat ($urandom_range(300, 6000)) @(posedge clk);
        end
        repeat (2000) @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Read-side video timing engine for the video memory. Generates 640x480@60 VGA timing from the system clock and scans the image region of vmem row by row, driving the pixel address. It registers the returned 24-bit pixel onto the VGA outputs with hsync, vsync and blank aligned to that pixel. vmem's write port stays with the CPU; this block only drives vmem's pixel-read side.

## Interface
- CLK_DIV, 2: system clocks per pixel (50 MHz clk -> 25 MHz pixel rate); must be >= 2.
- IMG_W, 256: image width in pixels, placed at the left edge of the active area.
- IMG_H, 256: image height in lines, placed at the top of the active area.
- ADDR_W, 18: pixel-address width; must satisfy IMG_W*IMG_H <= 2^ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- pxlAddr  out  ADDR_W  pixel address to vmem.
- R, G, B  in  8 each  pixel data from vmem.
- vgaR, vgaG, vgaB  out  8 each  pixel colour to the DAC.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- blank_n  out  1  high during the visible area.
- pxlStb  out  1  one-clk strobe per pixel period (DAC clock enable).
- frameStart  out  1  one-clk pulse at the start of each frame.

## Operation
- Divider `div` counts 0..CLK_DIV-1 and wraps. Pixel tick = (div == CLK_DIV-1). pxlStb = tick.
- On each tick, horizontal counter h counts 0..799 and wraps. When h wraps, vertical counter v counts 0..524 and wraps.
- Horizontal timing:
  - active h 0..639
  - front porch 640..655
  - sync pulse 656..751
  - back porch 752..799
- Vertical timing:
  - active v 0..479
  - front porch 480..489
  - sync pulse 490..491
  - back porch 492..524
- Stage 1, registered on the tick, from the current (h, v):
  - inImg = (h < IMG_W) && (v < IMG_H).
  - pxlAddr = v*IMG_W + h when inImg, else 0. Truncate to ADDR_W.
  - Also register act = (h < 640 && v < 480), hs = !(656 <= h <= 751), vs = !(490 <= v <= 491), and inImg.
- Stage 2, registered on the next tick:
  - vgaR/G/B = R/G/B if inImg_d, else 0. Outside the image but inside the active area, colour is black.
  - blank_n = act_d; hsync = hs_d; vsync = vs_d.
- frameStart pulses high for one clk on the tick where h == 0 and v == 0 are loaded into stage 1.
- The block has no handshake with vmem. vmem must present R/G/B for pxlAddr within CLK_DIV-1 clocks; this is met when vmem read latency is at most 1 clk with the default divider.
- Writes by the CPU to vmem during scan-out are allowed. Tearing is acceptable.

## Timing
- Reset, asynchronous:
  - div, h, v = 0; pxlAddr = 0
  - vgaR/G/B = 0; blank_n = 0
  - hsync = 1; vsync = 1
  - pxlStb = 0; frameStart = 0
  - all pipeline registers cleared
- First tick after reset release occurs at the CLK_DIV-th rising clk edge. That tick loads stage 1 for (h=0, v=0) and pulses frameStart.
- Latency:
  - pxlAddr for pixel (h, v) is valid 1 tick after the counters hold (h, v).
  - vgaR/G/B, blank_n, hsync and vsync for that pixel are valid 2 ticks after.
  - All outputs change only on tick edges, except pxlStb and frameStart, which are single-clk pulses.
- Line period: 800 ticks. Frame period: 525 lines = 420000 ticks = 840000 clk at CLK_DIV=2.
- hsync is low for exactly 96 consecutive ticks per line. vsync is low for exactly 2 lines (1600 ticks) per frame.
- Wrap-around: h=799 -> 0 and v increments on the same tick. At h=799, v=524, both wrap to 0.
- Reset mid-frame returns everything to reset values immediately, with no partial line completion. Scan restarts at (0, 0) with the same first-tick rule.
- Last image pixel (IMG_W-1, IMG_H-1) gives address IMG_W*IMG_H-1 = 65535 at the defaults. The address never exceeds this value.

## Test plan
- Reset check: assert reset for 3 clk and check all outputs hold their reset values. Release reset: first pxlStb occurs on the 2nd clk edge, together with frameStart=1.
- Horizontal timing: count ticks between hsync falling edges = 800; hsync low for 96 ticks; blank_n high for 640 ticks per active line. Check that the hsync falling edge is 656+1 ticks after the line's first pxlAddr change.
- Vertical timing: vsync low for 1600 ticks; 480 lines with blank_n activity per frame. frameStart period = 840000 clk.
- Addressing: mock vmem returns {addr[7:0], addr[15:8], 8'h5A} with 1-clk latency. At (h=1, v=2), pxlAddr = 513, and 2 ticks later vgaR=8'h01, vgaG=8'h02, vgaB=8'h5A.
- Border and blank: at (h=300, v=10) pxlAddr=0 and vgaRGB=0 with blank_n=1. At (h=700, v=10) vgaRGB=0 with blank_n=0. At (255, 255) pxlAddr=65535.
- Reset mid-frame: assert reset at v=300, h=400 -> outputs return to reset values at once; after release, the first frameStart and pxlAddr sequence restart from 0.
